// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the EX-stage ALU execute unit.
//   - ALUOp codes driven by the main control decoder
//   - funct[3:0] codes for R-type operations
//   - internal operation enum and execute FSM state encoding
//   - decode_op(): maps ALUOp/funct onto the internal operation
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0100;
  localparam logic [3:0] FN_OR  = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b1010;
  localparam logic [3:0] FN_MUL = 4'b1000;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLT = 3'd4,
    OP_MUL = 3'd5,
    OP_ILL = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Only the R-type path looks at funct; unknown funct values become OP_ILL.
  function automatic op_e decode_op(input logic [1:0] alu_op, input logic [3:0] funct);
    op_e op;
    case (alu_op)
      ALUOP_ADD: op = OP_ADD;
      ALUOP_SUB: op = OP_SUB;
      ALUOP_OR:  op = OP_OR;
      ALUOP_RTYPE: begin
        case (funct)
          FN_ADD:  op = OP_ADD;
          FN_SUB:  op = OP_SUB;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_SLT:  op = OP_SLT;
          FN_MUL:  op = OP_MUL;
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// alu_mul_iter: iterative shift-add multiplier, MUL_BITS multiplier bits per cycle.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   start_i           load operand shadows, clear accumulator, arm counter
//   flush_i           abandon the multiply in flight
//   a_i, b_i          operands (sampled only on start_i)
//   done_o            the current cycle performs the final step
//   product_o         accumulator value after the current step (low WIDTH bits);
//                     it is the finished product when done_o is high
module alu_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int STEPS = WIDTH / MUL_BITS;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             active_r;
  logic [WIDTH-1:0] acc_next_s;

  // Sum of the shifted multiplicand for every set bit in the low MUL_BITS of b.
  function automatic logic [WIDTH-1:0] partial_product(input logic [WIDTH-1:0] a,
                                                        input logic [MUL_BITS-1:0] b);
    logic [WIDTH-1:0] sum;
    sum = {WIDTH{1'b0}};
    for (int i = 0; i < MUL_BITS; i++) begin
      sum = sum + ((a & {WIDTH{b[i]}}) << i);
    end
    return sum;
  endfunction

  // Next accumulator value and completion flag for the step taken this cycle.
  always_comb begin
    acc_next_s = acc_r + partial_product(a_sh_r, b_sh_r[MUL_BITS-1:0]);
    done_o     = active_r & (cnt_r == CNT_W'(1));
    product_o  = acc_next_s;
  end

  // Shadow registers, accumulator and step counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      active_r <= 1'b0;
    end else if (flush_i) begin
      active_r <= 1'b0;
    end else if (start_i) begin
      a_sh_r   <= a_i;
      b_sh_r   <= b_i;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= CNT_W'(STEPS);
      active_r <= 1'b1;
    end else if (active_r) begin
      acc_r  <= acc_next_s;
      a_sh_r <= a_sh_r << MUL_BITS;
      b_sh_r <= b_sh_r >> MUL_BITS;
      cnt_r  <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) begin
        active_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with merged ALUOp/funct decode, single-cycle
// add/sub/and/or/slt and an iterative multiplier behind a valid/ready handshake.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   flush_i             synchronous abort of an in-flight multiply (blocks accept)
//   valid_i / ready_o   operation request / unit can accept this cycle
//   ALUOp_i, funct_i    operation select (funct_i[3:0] decoded when ALUOp_i=11)
//   data1_i, data2_i    operands A and B
//   result_o, zero_o    registered result and result==0 flag
//   valid_o             one-cycle pulse when result_o is updated
//   illegal_o           with valid_o: the op had an undecodable funct
//   busy_o              multiply in flight, stalls IF/ID/EX
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             illegal_o,
  output logic             busy_o
);

  op_e              op_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             accept_s;
  logic             mul_start_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_prod_s;
  state_e           state_r;
  state_e           state_next_s;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             valid_r;
  logic             illegal_r;
  logic             busy_r;
  logic             ready_r;
  logic             unused_funct_s;

  // funct_i[5:4] carry no meaning for this unit.
  assign unused_funct_s = &{1'b0, funct_i[5:4]};

  // Decode and single-cycle datapath; mul and illegal ops produce zero here.
  always_comb begin
    op_s      = decode_op(ALUOp_i, funct_i[3:0]);
    alu_res_s = {WIDTH{1'b0}};
    case (op_s)
      OP_ADD:  alu_res_s = data1_i + data2_i;
      OP_SUB:  alu_res_s = data1_i - data2_i;
      OP_AND:  alu_res_s = data1_i & data2_i;
      OP_OR:   alu_res_s = data1_i | data2_i;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
    accept_s    = valid_i & ready_r & ~flush_i;
    mul_start_s = accept_s & (op_s == OP_MUL);
  end

  alu_mul_iter #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (mul_start_s),
    .flush_i   (flush_i),
    .a_i       (data1_i),
    .b_i       (data2_i),
    .done_o    (mul_done_s),
    .product_o (mul_prod_s)
  );

  // Next-state logic; DONE behaves like IDLE for accepting a new op.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (mul_start_s) begin
          state_next_s = MUL;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_next_s = IDLE;
        end else if (mul_done_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MUL;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state and registered outputs; result/zero/illegal hold between pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      result_r  <= {WIDTH{1'b0}};
      zero_r    <= 1'b1;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == MUL);
      ready_r <= (state_next_s != MUL);
      valid_r <= 1'b0;
      if ((state_r == MUL) && !flush_i && mul_done_s) begin
        result_r  <= mul_prod_s;
        zero_r    <= (mul_prod_s == {WIDTH{1'b0}});
        valid_r   <= 1'b1;
        illegal_r <= 1'b0;
      end else if (accept_s && (op_s != OP_MUL)) begin
        result_r  <= alu_res_s;
        zero_r    <= (alu_res_s == {WIDTH{1'b0}});
        valid_r   <= 1'b1;
        illegal_r <= (op_s == OP_ILL);
      end
    end
  end

  assign result_o  = result_r;
  assign zero_o    = zero_r;
  assign valid_o   = valid_r;
  assign illegal_o = illegal_r;
  assign busy_o    = busy_r;
  assign ready_o   = ready_r;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed and randomized operations checked
// against a behavioural model; a second instance covers MUL_BITS=4.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, valid, ready, zero, vout, ill, busy;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b, res;

  logic         flush4, valid4, ready4, zero4, vout4, ill4, busy4;
  logic [1:0]   aluop4;
  logic [5:0]   funct4;
  logic [W-1:0] a4, b4, res4;

  int total = 0;
  int bad   = 0;
  int lat, cnt;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .MUL_BITS(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
    .ALUOp_i(aluop), .funct_i(funct), .data1_i(a), .data2_i(b), .result_o(res),
    .zero_o(zero), .valid_o(vout), .illegal_o(ill), .busy_o(busy));

  alu_exec_unit #(.WIDTH(W), .MUL_BITS(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush4), .valid_i(valid4), .ready_o(ready4),
    .ALUOp_i(aluop4), .funct_i(funct4), .data1_i(a4), .data2_i(b4), .result_o(res4),
    .zero_o(zero4), .valid_o(vout4), .illegal_o(ill4), .busy_o(busy4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: {illegal, result} straight from the operation table.
  function automatic logic [W:0] model(input logic [1:0] op, input logic [5:0] fn,
                                       input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         il;
    r  = '0;
    il = 1'b0;
    if (op == 2'd0) r = x + y;
    else if (op == 2'd1) r = x - y;
    else if (op == 2'd2) r = x | y;
    else begin
      case (fn[3:0])
        4'd0:    r = x + y;
        4'd2:    r = x - y;
        4'd4:    r = x & y;
        4'd5:    r = x | y;
        4'd10:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
        4'd8:    r = x * y;
        default: il = 1'b1;
      endcase
    end
    return {il, r};
  endfunction

  // Issue one op at a negedge and check latency, result, flags and busy span.
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] m;
    int         l, bcnt, exp_lat;
    bit         is_mul;
    m       = model(op, fn, x, y);
    is_mul  = (op == 2'b11) && (fn[3:0] == 4'd8);
    exp_lat = is_mul ? W + 1 : 1;
    aluop = op; funct = fn; a = x; b = y; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    l     = 1;
    bcnt  = 0;
    while (!vout && l < 200) begin
      bcnt += int'(busy);
      a = $urandom;  // operands are shadowed, so this must not matter
      b = $urandom;
      @(negedge clk);
      l++;
    end
    chk("latency", 64'(l), 64'(exp_lat));
    chk("result", 64'(res), 64'(m[W-1:0]));
    chk("zero", 64'(zero), 64'(m[W-1:0] == '0));
    chk("illegal", 64'(ill), 64'(m[W]));
    chk("busy_at_valid", 64'(busy), 64'd0);
    if (is_mul) chk("busy_cycles", 64'(bcnt), 64'(W));
    @(negedge clk);
    chk("valid_pulse", 64'(vout), 64'd0);
    chk("ready_after", 64'(ready), 64'd1);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [5:0]   rfn;
    logic [W-1:0] rx, ry;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; aluop = '0; funct = '0; a = '0; b = '0;
    flush4 = 1'b0; valid4 = 1'b0; aluop4 = '0; funct4 = '0; a4 = '0; b4 = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_result", 64'(res), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_valid", 64'(vout), 64'd0);
    chk("rst_illegal", 64'(ill), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    do_op(2'b11, 6'b100000, 32'd7, 32'd5);
    do_op(2'b11, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    do_op(2'b01, 6'b000000, 32'd3, 32'd3);
    do_op(2'b11, 6'b011000, 32'h0000_FFFF, 32'h0001_0001);
    do_op(2'b11, 6'b000111, 32'd1, 32'd2);
    do_op(2'b10, 6'b111111, 32'h0000_00F0, 32'h0000_000F);
    do_op(2'b00, 6'b000010, 32'hFFFF_FFFF, 32'd1);
    do_op(2'b11, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00);
    do_op(2'b11, 6'b101010, 32'd5, 32'hFFFF_FFFD);
    do_op(2'b11, 6'b100010, 32'd0, 32'd1);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0: rfn = {2'($urandom), 4'd0};
        1: rfn = {2'($urandom), 4'd2};
        2: rfn = {2'($urandom), 4'd4};
        3: rfn = {2'($urandom), 4'd5};
        4: rfn = {2'($urandom), 4'd10};
        5: rfn = {2'($urandom), 4'd8};
        default: rfn = 6'($urandom);
      endcase
      rx = (i % 4 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      ry = (i % 5 == 0) ? 32'h8000_0000 : W'($urandom);
      do_op(rop, rfn, rx, ry);
    end

    // Request held during MUL is taken only in DONE, back-to-back
    aluop = 2'b11; funct = 6'b011000; a = 32'd100; b = 32'd3; valid = 1'b1;
    @(negedge clk);
    aluop = 2'b00; a = 32'd10; b = 32'd20;
    lat = 1;
    while (!vout && lat < 200) begin @(negedge clk); lat++; end
    chk("b2b_mul_latency", 64'(lat), 64'(W + 1));
    chk("b2b_mul_result", 64'(res), 64'd300);
    chk("b2b_ready_in_done", 64'(ready), 64'd1);
    @(negedge clk);
    valid = 1'b0;
    chk("b2b_add_valid", 64'(vout), 64'd1);
    chk("b2b_add_result", 64'(res), 64'd30);
    @(negedge clk);

    // Flush mid-multiply
    aluop = 2'b11; funct = 6'b011000; a = 32'd9; b = 32'd9; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_valid", 64'(vout), 64'd0);
    chk("flush_result", 64'(res), 64'd30);
    chk("flush_ready", 64'(ready), 64'd1);
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += int'(vout); end
    chk("flush_no_valid", 64'(cnt), 64'd0);

    // Flush together with valid: nothing accepted
    aluop = 2'b00; a = 32'd1; b = 32'd1; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flushvalid_add", 64'(vout), 64'd0);
    aluop = 2'b11; funct = 6'b011000;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    chk("flushvalid_mul_busy", 64'(busy), 64'd0);
    chk("flushvalid_result", 64'(res), 64'd30);

    // Flush during DONE: result still delivered, new request blocked
    aluop = 2'b11; funct = 6'b011000; a = 32'd6; b = 32'd7; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lat = 1;
    while (!vout && lat < 200) begin @(negedge clk); lat++; end
    chk("done_flush_result", 64'(res), 64'd42);
    aluop = 2'b00; a = 32'd2; b = 32'd2; valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    chk("done_flush_valid", 64'(vout), 64'd0);
    chk("done_flush_ready", 64'(ready), 64'd1);
    chk("done_flush_hold", 64'(res), 64'd42);

    // Reset mid-multiply
    aluop = 2'b11; funct = 6'b011000; a = 32'd5; b = 32'd6; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_result", 64'(res), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd1);
    chk("midrst_valid", 64'(vout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin @(negedge clk); cnt += int'(vout); end
    chk("midrst_no_valid", 64'(cnt), 64'd0);

    // MUL_BITS=4 instance: latency WIDTH/4+1
    aluop4 = 2'b11; funct4 = 6'b011000; a4 = 32'h0000_FFFF; b4 = 32'h0001_0001; valid4 = 1'b1;
    @(negedge clk);
    valid4 = 1'b0; a4 = 32'hDEAD_BEEF; b4 = 32'h1234_5678;
    lat = 1;
    while (!vout4 && lat < 100) begin @(negedge clk); lat++; end
    chk("mul4_latency", 64'(lat), 64'(W / 4 + 1));
    chk("mul4_result", 64'(res4), 64'hFFFF_FFFF);
    chk("mul4_busy", 64'(busy4), 64'd0);
    chk("mul4_illegal", 64'(ill4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode; merges ALUOp/funct decode with the execute datapath.
- Adds an iterative multi-cycle multiplier and a valid/ready handshake.
- Sits in the EX stage. busy_o drives the hazard unit's stall of IF/ID/EX while a multiply is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- MUL_BITS, 1, multiplier bits retired per cycle (1, 2 or 4; must divide WIDTH).
- CNT_W, $clog2(WIDTH/MUL_BITS)+1, iteration counter width (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous abort of any in-flight operation.
- valid_i  in  1  operation request.
- ready_o  out  1  unit can accept an operation this cycle.
- ALUOp_i  in  2  00 add, 01 sub, 10 or, 11 R-type (use funct_i).
- funct_i  in  6  R-type function; only [3:0] decoded.
- data1_i  in  WIDTH  operand A.
- data2_i  in  WIDTH  operand B.
- result_o  out  WIDTH  registered result.
- zero_o  out  1  result_o == 0.
- valid_o  out  1  one-cycle pulse: result_o updated this cycle.
- illegal_o  out  1  qualifies valid_o: the accepted op had an undecodable funct.
- busy_o  out  1  multiply in flight (stall request).

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; result_o=0, zero_o=1, valid_o=0, illegal_o=0, busy_o=0, ready_o=1.
  - Multiplier accumulator, operand shadows and counter are cleared.
- Decode when ALUOp=11, on funct[3:0]:
  - 0000 add, 0010 sub, 0100 and, 0101 or, 1010 slt (signed), 1000 mul.
  - Any other value is illegal.
  - ALUOp 00/01/10 ignore funct_i.
- Accept rule: accept = valid_i & ready_o & ~flush_i.
- ready_o = (state==IDLE) | (state==DONE).
- Single-cycle ops (add/sub/and/or/slt):
  - Latency 1: result_o and valid_o are registered on the edge after accept.
  - State stays IDLE.
  - add/sub wrap modulo 2^WIDTH; no overflow flag.
  - slt yields {WIDTH-1 zeros, (signed A < signed B)}.
- Illegal op:
  - Latency 1, result_o=0, valid_o=1, illegal_o=1.
  - No state change.
- mul:
  - On accept, latch A and B into shadows, clear the accumulator, counter=WIDTH/MUL_BITS; go IDLE->MUL.
  - busy_o=1 from the cycle after accept until the DONE cycle, exclusive.
  - Each MUL cycle adds (A shifted) x (low MUL_BITS of B), shifts B right by MUL_BITS and decrements the counter.
  - When the counter reaches 1 on an edge, go MUL->DONE.
  - In DONE: result_o = low WIDTH bits of the unsigned product (equal to the signed low half), valid_o=1, busy_o=0.
  - Total latency from accept to valid_o = WIDTH/MUL_BITS + 1 cycles (33 at defaults).
- DONE:
  - Lasts exactly one cycle, then goes to IDLE.
  - A new op may be accepted in the DONE cycle (back-to-back).
- valid_i while in MUL: ignored (ready_o=0). The requester must hold its request; the pipeline is stalled by busy_o.
- flush_i:
  - In MUL: returns to IDLE next edge; busy_o=0; no valid_o; result_o keeps its previous value.
  - With valid_i in the same cycle: flush wins, the op is not accepted.
  - In DONE: valid_o is still produced this cycle; next state is IDLE.
- Output hold:
  - result_o and zero_o hold between valid_o pulses.
  - illegal_o is cleared on the next valid_o of a legal op and is only meaningful when valid_o=1.
- Reset mid-multiply: immediate return to the reset values; no partial result appears.
- Operand changes on data*_i during MUL have no effect (shadowed).

Decomposition:
- Package alu_pkg holds:
  - ALUOp codes (ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_OR=2'b10, ALUOP_RTYPE=2'b11).
  - funct[3:0] codes: FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL.
  - Internal op enum: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL, OP_ILL.
  - FSM state encoding: IDLE, MUL, DONE.
- One sub-module, alu_mul_iter, is natural:
  - Parametrised WIDTH/MUL_BITS; start/flush in, done/product out.
  - Owns the counter, shadows and accumulator.
- The top keeps decode, the single-cycle datapath and the FSM.

Test Plan:
- Reset then ALUOp=11, funct=100000, A=7, B=5, valid_i=1 for 1 cycle -> next cycle valid_o=1, result_o=12, zero_o=0, busy_o=0.
- ALUOp=11 funct=101010 A=0xFFFFFFFF(-1) B=1 -> result_o=1. Then ALUOp=01 A=3 B=3 -> result_o=0, zero_o=1.
- ALUOp=11 funct=011000 A=0xFFFF B=0x10001, MUL_BITS=1 -> busy_o=1 for 32 cycles; valid_o 33 cycles after accept with result_o=0xFFFFFFFF. Repeat with MUL_BITS=4: latency 9.
- mul accepted, new valid_i asserted during MUL -> not accepted until DONE. In DONE, an add is accepted back-to-back and its valid_o appears the next cycle.
- mul in flight, flush_i at cycle 10 -> no valid_o, busy_o=0 next cycle, result_o unchanged. flush_i+valid_i together -> no accept.
- ALUOp=11 funct=000111 -> valid_o=1, illegal_o=1, result_o=0. Assert rst_i mid-multiply -> outputs at reset values immediately, ready_o=1.
